lsu_bus: RTL and testbench
==========================

LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles spent in WAIT before a timeout error; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 in_valid / in_ready  input / output  1 / 1  core request handshake.
REQ-007 in_wen  input  1  1 = store, 0 = load.
REQ-008 in_func3  input  3  RISC-V width/sign encoding (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
REQ-009 in_addr / in_wdata  input  ADDR_W / XLEN  byte address and unshifted store data.
REQ-010 out_valid / out_ready  output / input  1 / 1  response handshake to the core.
REQ-011 out_rdata  output  XLEN  extended load data; 0 for stores and errors.
REQ-012 out_err  output  2  error code: 00 none, 01 misaligned or illegal func3, 10 bus error, 11 timeout.
REQ-013 mem_req / mem_gnt  output / input  1 / 1  bus request and grant.
REQ-014 mem_we, mem_addr, mem_wdata, mem_wmask  output  1, ADDR_W, XLEN, XLEN/8  bus command; mem_addr is aligned to XLEN/8 bytes.
REQ-015 mem_rvalid, mem_rdata, mem_err  input  1, XLEN, 1  bus completion (loads and stores), data, and error flag.

Function
REQ-016 The FSM has four states: IDLE, REQ, WAIT and RESP.
REQ-017 in_ready = 1 only in IDLE; a request is accepted when in_valid && in_ready, and the LSU registers addr, func3, wen and wdata.
REQ-018 Alignment check on accept: H needs addr[0]=0; W/WU needs addr[1:0]=0; D needs addr[2:0]=0.
REQ-019 Illegal func3: D, WU, or 111 when XLEN=32; 111 or store with func3[2]=1 for any XLEN.
REQ-020 A misaligned or illegal request goes IDLE->RESP directly with err=01, issues no bus transaction, and performs no write.
REQ-021 A legal request goes IDLE->REQ; mem_req = 1 only in REQ; the command outputs are stable while mem_req=1 && !mem_gnt.
REQ-022 REQ->WAIT on mem_gnt; mem_gnt in the same cycle mem_req first asserts is legal, giving a 1-cycle REQ.
REQ-023 WAIT->RESP on mem_rvalid; err=10 if mem_err=1, otherwise load data is captured.
REQ-024 Store mask: byte enables = (width mask) << addr offset.
REQ-025 Store data: mem_wdata = in_wdata << (8*offset); offset = addr mod XLEN/8.
REQ-026 Load data: extract the lane at offset, then sign-extend (B/H/W) or zero-extend (BU/HU/WU); D passes through.
REQ-027 Timeout: a WAIT counter resets on entry to WAIT; reaching TIMEOUT goes to RESP with err=11, and a late mem_rvalid is then ignored.
REQ-028 out_valid = 1 only in RESP, with outputs held stable; RESP->IDLE on out_ready.
REQ-029 Latency: a legal access with immediate gnt and rvalid in the next cycle gives out_valid 3 cycles after accept.
REQ-030 Back-to-back: the next request can be accepted in the cycle after the RESP handshake, never the same cycle.
REQ-031 mem_rvalid outside WAIT is ignored.

Reset
REQ-032 When rst=0 at a clock edge: state=IDLE, counter=0, and all registers are cleared.
REQ-033 Reset output values: in_ready=1, out_valid=0, out_rdata=0, out_err=00, mem_req=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset mid-transaction aborts it; no response is produced, and bus responses arriving after reset are ignored per REQ-031.

Structure
REQ-035 A shared package holds the LsuState enum, the LsuErr enum, and the func3 width constants.
REQ-036 One sub-module, lsu_align, is purely combinational: mask/shift generation, load extraction/extension, and the misalignment check.
REQ-037 The FSM, timeout counter and registers live in lsu_bus.

Verification
REQ-038 XLEN=32, SB addr=0x80000003 wdata=0xAB -> mem_addr=0x80000000, wmask=1000, wdata=0xAB000000, out_err=00.
REQ-039 XLEN=32, LH addr=0x2 with mem_rdata=0x8001_0000 -> out_rdata=0xFFFF8001; LHU -> 0x00008001.
REQ-040 XLEN=32, LW addr=0x6 -> no mem_req ever, out_valid next cycle, out_err=01.
REQ-041 XLEN=64, LWU addr=0x4, rdata=0xF0000000_00000000 -> out_rdata=0x00000000_F0000000.
REQ-042 TIMEOUT=4, gnt given, rvalid withheld -> out_err=11 after 4 WAIT cycles; a later rvalid has no effect.
REQ-043 mem_gnt low for 3 cycles, out_ready low for 2 cycles, then rst=0 during WAIT on a second access -> command and response held stable; after reset state is IDLE with REQ-033 values.

Source files
------------

// File: rtl/lsu_bus_pkg.sv
// Shared types for the load/store unit bus adapter: FSM states, error codes
// and the RISC-V func3 width/sign encodings.
package lsu_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_RESP = 2'b11
   } lsu_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_ALIGN   = 2'b01,
      ERR_BUS     = 2'b10,
      ERR_TIMEOUT = 2'b11
   } lsu_err_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

endpackage

// File: rtl/lsu_bus_align.sv
// Combinational lane logic: request legality/alignment check, store byte
// enables and data shift, and load lane extraction with sign/zero extension.
module lsu_align
   import lsu_bus_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int NB    = XLEN / 8,
   localparam int OFF_W = $clog2(XLEN / 8)
) (
   input  logic [2:0]       req_func3,
   input  logic             req_wen,
   input  logic [OFF_W-1:0] req_off,
   input  logic [XLEN-1:0]  req_wdata,
   output logic             req_bad,
   output logic [NB-1:0]    req_wmask,
   output logic [XLEN-1:0]  req_wdata_sh,
   input  logic [2:0]       ld_func3,
   input  logic [OFF_W-1:0] ld_off,
   input  logic [XLEN-1:0]  ld_rdata,
   output logic [XLEN-1:0]  ld_data
);

   logic            illegal;
   logic            misaligned;
   logic [NB-1:0]   size_mask;
   logic [XLEN-1:0] lane;

   // legality, alignment and store lane placement for the incoming request
   always_comb begin
      illegal = (req_func3 == 3'b111) || (req_wen && req_func3[2]) ||
                ((XLEN == 32) && ((req_func3 == F3_D) || (req_func3 == F3_WU)));
      misaligned = 1'b0;
      size_mask  = '1;
      case (req_func3[1:0])
         2'b00: begin misaligned = 1'b0;            size_mask = NB'(1);  end
         2'b01: begin misaligned = req_off[0];      size_mask = NB'(3);  end
         2'b10: begin misaligned = |req_off[1:0];   size_mask = NB'(15); end
         default: begin misaligned = |req_off;      size_mask = '1;      end
      endcase
      req_bad      = illegal || misaligned;
      req_wmask    = size_mask << req_off;
      req_wdata_sh = req_wdata << {req_off, 3'b000};
   end

   // pull the addressed lane down to bit 0 and extend it to XLEN
   always_comb begin
      lane = ld_rdata >> {ld_off, 3'b000};
      case (ld_func3)
         F3_B:    ld_data = XLEN'($signed(lane[7:0]));
         F3_H:    ld_data = XLEN'($signed(lane[15:0]));
         F3_W:    ld_data = XLEN'($signed(lane[31:0]));
         F3_BU:   ld_data = XLEN'(lane[7:0]);
         F3_HU:   ld_data = XLEN'(lane[15:0]);
         F3_WU:   ld_data = XLEN'(lane[31:0]);
         F3_D:    ld_data = lane;
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: accepts one core request at a time, issues a
// single bus transaction and returns an extended load result or error code.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a core request
// ST_REQ  | bus command presented, waiting for mem_gnt
// ST_WAIT | granted, waiting for mem_rvalid or timeout
// ST_RESP | response presented to the core, waiting for out_ready
module lsu_bus
   import lsu_bus_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_wen,
   input  logic [2:0]        in_func3,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_rdata,
   output logic [1:0]        out_err,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wmask,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_err
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // down-counter preload: terminal count 0 is reached on the TIMEOUT-th WAIT cycle
   localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   lsu_state_e       state;
   logic [2:0]       func3_q;
   logic [OFF_W-1:0] off_q;
   logic             wen_q;
   logic [CNT_W-1:0] cnt;

   logic             req_bad;
   logic [NB-1:0]    req_wmask;
   logic [XLEN-1:0]  req_wdata_sh;
   logic [XLEN-1:0]  ld_data;

   assign in_ready  = (state == ST_IDLE);
   assign mem_req   = (state == ST_REQ);
   assign out_valid = (state == ST_RESP);

   lsu_align #(.XLEN(XLEN)) u_align (
      .req_func3    (in_func3),
      .req_wen      (in_wen),
      .req_off      (in_addr[OFF_W-1:0]),
      .req_wdata    (in_wdata),
      .req_bad      (req_bad),
      .req_wmask    (req_wmask),
      .req_wdata_sh (req_wdata_sh),
      .ld_func3     (func3_q),
      .ld_off       (off_q),
      .ld_rdata     (mem_rdata),
      .ld_data      (ld_data)
   );

   // request FSM, timeout counter and registered bus/response outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         func3_q   <= '0;
         off_q     <= '0;
         wen_q     <= 1'b0;
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         out_rdata <= '0;
         out_err   <= ERR_NONE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  func3_q   <= in_func3;
                  off_q     <= in_addr[OFF_W-1:0];
                  wen_q     <= in_wen;
                  out_rdata <= '0;
                  if (req_bad) begin
                     out_err <= ERR_ALIGN;
                     state   <= ST_RESP;
                  end else begin
                     out_err   <= ERR_NONE;
                     mem_we    <= in_wen;
                     mem_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                     mem_wdata <= in_wen ? req_wdata_sh : '0;
                     mem_wmask <= in_wen ? req_wmask : '0;
                     state     <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (mem_gnt) begin
                  cnt   <= TO_LOAD;
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state <= ST_RESP;
                  if (mem_err) begin
                     out_err <= ERR_BUS;
                  end else begin
                     out_rdata <= wen_q ? '0 : ld_data;
                  end
               end else if ((TIMEOUT != 0) && (cnt == '0)) begin
                  out_err <= ERR_TIMEOUT;
                  state   <= ST_RESP;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus.sv
// Scoreboard bench for lsu_bus: a 32-bit instance (short timeout) and a
// 64-bit instance share stimulus; sel picks which one is being exercised.
module tb_lsu_bus;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   always #5 clk = ~clk;

   logic        v32, v64, in_wen, out_ready, mem_gnt, mem_rvalid, mem_err;
   logic [2:0]  in_func3;
   logic [31:0] in_addr;
   logic [63:0] in_wdata, mem_rdata;

   logic        rdy_a, ov_a, mreq_a, mwe_a;
   logic [1:0]  err_a;
   logic [31:0] rdata_a, maddr_a, mwdata_a;
   logic [3:0]  mwmask_a;

   logic        rdy_b, ov_b, mreq_b, mwe_b;
   logic [1:0]  err_b;
   logic [63:0] rdata_b, mwdata_b;
   logic [31:0] maddr_b;
   logic [7:0]  mwmask_b;

   bit          sel;
   logic        rdy_o, ov_o, mreq_o, mwe_o;
   logic [1:0]  err_o;
   logic [63:0] rdata_o, mwdata_o;
   logic [31:0] maddr_o;
   logic [7:0]  mwmask_o;

   assign rdy_o    = sel ? rdy_b    : rdy_a;
   assign ov_o     = sel ? ov_b     : ov_a;
   assign mreq_o   = sel ? mreq_b   : mreq_a;
   assign mwe_o    = sel ? mwe_b    : mwe_a;
   assign err_o    = sel ? err_b    : err_a;
   assign rdata_o  = sel ? rdata_b  : {32'h0, rdata_a};
   assign mwdata_o = sel ? mwdata_b : {32'h0, mwdata_a};
   assign maddr_o  = sel ? maddr_b  : maddr_a;
   assign mwmask_o = sel ? mwmask_b : {4'h0, mwmask_a};

   lsu_bus #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) u_dut32 (
      .clk(clk), .rst(rst),
      .in_valid(v32), .in_ready(rdy_a), .in_wen(in_wen), .in_func3(in_func3),
      .in_addr(in_addr), .in_wdata(in_wdata[31:0]),
      .out_valid(ov_a), .out_ready(out_ready), .out_rdata(rdata_a), .out_err(err_a),
      .mem_req(mreq_a), .mem_gnt(mem_gnt), .mem_we(mwe_a), .mem_addr(maddr_a),
      .mem_wdata(mwdata_a), .mem_wmask(mwmask_a),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err)
   );

   lsu_bus #(.XLEN(64), .ADDR_W(32)) u_dut64 (
      .clk(clk), .rst(rst),
      .in_valid(v64), .in_ready(rdy_b), .in_wen(in_wen), .in_func3(in_func3),
      .in_addr(in_addr), .in_wdata(in_wdata),
      .out_valid(ov_b), .out_ready(out_ready), .out_rdata(rdata_b), .out_err(err_b),
      .mem_req(mreq_b), .mem_gnt(mem_gnt), .mem_we(mwe_b), .mem_addr(maddr_b),
      .mem_wdata(mwdata_b), .mem_wmask(mwmask_b),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   typedef struct packed {
      logic [63:0] rdata;
      logic [1:0]  err;
   } resp_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } cmd_t;

   resp_t rsp_q[$];
   cmd_t  cmd_q[$];
   int    n_chk = 0;
   int    n_err = 0;
   int    cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_bad(input int xl, input bit wen, input logic [2:0] f3,
                                    input logic [31:0] addr);
      int sz;
      sz = 1 << f3[1:0];
      if (f3 == 3'b111) return 1'b1;
      if (wen && f3[2]) return 1'b1;
      if (xl == 32 && (f3 == 3'b011 || f3 == 3'b110)) return 1'b1;
      return (addr % sz) != 0;
   endfunction

   function automatic logic [63:0] model_load(input int xl, input logic [2:0] f3, input int off,
                                              input logic [63:0] rd);
      int          n;
      logic [63:0] v;
      n = 1 << f3[1:0];
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
      if (!f3[2] && n * 8 < xl && v[8*n-1])
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      if (xl == 32) v[63:32] = '0;
      return v;
   endfunction

   function automatic logic [7:0] model_mask(input int n, input int off);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[off+i] = 1'b1;
      return m;
   endfunction

   // one complete access: push expectations, drive, play the bus, check the response
   task automatic access(input bit s, input bit wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd, input bit berr,
                         input int gdly, input int rdly, input bit hold);
      int    xl, nb, off, n, t0, k, exp_lat;
      bit    bad, ok;
      resp_t r;
      cmd_t  c;
      resp_t er;
      xl  = s ? 64 : 32;
      nb  = xl / 8;
      off = addr % nb;
      n   = 1 << f3[1:0];
      bad = model_bad(xl, wen, f3, addr);
      r.err   = bad ? 2'b01 : hold ? 2'b11 : berr ? 2'b10 : 2'b00;
      r.rdata = (r.err != 2'b00 || wen) ? 64'h0 : model_load(xl, f3, off, rd);
      rsp_q.push_back(r);
      if (!bad) begin
         c.we    = wen;
         c.addr  = addr & ~32'(nb - 1);
         c.wmask = wen ? model_mask(n, off) : 8'h0;
         c.wdata = wd << (8 * off);
         if (xl == 32) c.wdata[63:32] = '0;
         cmd_q.push_back(c);
      end
      exp_lat = bad ? 1 : hold ? 2 + gdly + TO : 3 + gdly;
      sel = s;
      @(negedge clk);
      in_wen = wen; in_func3 = f3; in_addr = addr; in_wdata = wd;
      if (s) v64 = 1'b1; else v32 = 1'b1;
      k = 0;
      while (!rdy_o && k < 20) begin @(negedge clk); k++; end
      chk("in_ready", rdy_o, 1);
      t0 = cyc;
      @(posedge clk); #1;
      v32 = 1'b0; v64 = 1'b0;
      if (!bad) begin
         k = 0; ok = 1'b0;
         while (k <= gdly + 20 && !ok) begin
            @(negedge clk);
            chk("mem_req", mreq_o, 1);
            if (!mreq_o) break;
            chk("cmd_we", mwe_o, cmd_q[0].we);
            chk("cmd_addr", maddr_o, cmd_q[0].addr);
            if (cmd_q[0].we) begin
               chk("cmd_wmask", mwmask_o, cmd_q[0].wmask);
               chk("cmd_wdata", mwdata_o, cmd_q[0].wdata);
            end
            if (k >= gdly) begin
               mem_gnt = 1'b1;
               @(posedge clk); #1;
               mem_gnt = 1'b0;
               void'(cmd_q.pop_front());
               ok = 1'b1;
            end
            k++;
         end
         chk("granted", ok, 1);
         if (!hold) begin
            @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = rd; mem_err = berr;
            @(posedge clk); #1;
            mem_rvalid = 1'b0; mem_err = 1'b0;
         end else begin
            for (int i = 0; i < TO; i++) begin
               @(negedge clk);
               chk("to_wait", ov_o, 0);
            end
         end
      end
      @(negedge clk);
      chk("out_valid", ov_o, 1);
      chk("latency", cyc - t0, exp_lat);
      if (bad) chk("no_mem_req", mreq_o, 0);
      if (hold) begin
         mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; mem_err = 1'b0;
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         @(negedge clk);
      end
      er = rsp_q.pop_front();
      chk("rdata", rdata_o, er.rdata);
      chk("err", err_o, er.err);
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk);
         chk("hold_valid", ov_o, 1);
         chk("hold_rdata", rdata_o, er.rdata);
         chk("hold_err", err_o, er.err);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("b2b_ready", rdy_o, 1);
      chk("b2b_valid", ov_o, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, rdy_o, 1);
      chk({tag, "_out_valid"}, ov_o, 0);
      chk({tag, "_out_rdata"}, rdata_o, 0);
      chk({tag, "_out_err"}, err_o, 0);
      chk({tag, "_mem_req"}, mreq_o, 0);
      chk({tag, "_mem_we"}, mwe_o, 0);
      chk({tag, "_mem_wmask"}, mwmask_o, 0);
      chk({tag, "_mem_addr"}, maddr_o, 0);
      chk({tag, "_mem_wdata"}, mwdata_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  lf [5];
      bit          w;
      logic [2:0]  f;
      logic [31:0] a;
      int          n;
      lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;
      v32 = 0; v64 = 0; in_wen = 0; in_func3 = 0; in_addr = 0; in_wdata = 0;
      out_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0; sel = 0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      sel = 0; check_reset_outputs("rst32");
      sel = 1; check_reset_outputs("rst64");
      rst = 1'b1;

      // directed XLEN=32 vectors
      access(0, 1, 3'b000, 32'h8000_0003, 64'hAB, 64'h0, 0, 3, 2, 0);
      access(0, 0, 3'b001, 32'h0000_0002, 64'h0, 64'h8001_0000, 0, 0, 0, 0);
      access(0, 0, 3'b101, 32'h0000_0002, 64'h0, 64'h8001_0000, 0, 0, 1, 0);
      access(0, 0, 3'b010, 32'h0000_0006, 64'h0, 64'h0, 0, 0, 0, 0);
      access(0, 0, 3'b010, 32'h0000_0008, 64'h0, 64'h0, 0, 0, 1, 1);
      access(0, 0, 3'b000, 32'h0000_0001, 64'h0, 64'h0000_7F00, 1, 1, 0, 0);
      access(0, 0, 3'b000, 32'h0000_0001, 64'h0, 64'h0000_8000, 0, 0, 0, 0);
      access(0, 1, 3'b011, 32'h0000_0000, 64'h1, 64'h0, 0, 0, 0, 0);
      access(0, 0, 3'b110, 32'h0000_0000, 64'h0, 64'h0, 0, 0, 0, 0);
      access(0, 0, 3'b111, 32'h0000_0000, 64'h0, 64'h0, 0, 0, 0, 0);
      access(0, 1, 3'b100, 32'h0000_0000, 64'h1, 64'h0, 0, 0, 0, 0);
      access(0, 0, 3'b001, 32'h0000_0001, 64'h0, 64'h0, 0, 0, 0, 0);
      access(0, 1, 3'b010, 32'h0000_0010, 64'h1234_5678, 64'h0, 0, 0, 0, 0);
      access(0, 1, 3'b001, 32'h0000_0006, 64'hBEEF, 64'h0, 0, 2, 0, 0);
      access(0, 1, 3'b010, 32'h0000_0020, 64'hCAFE_F00D, 64'h0, 1, 0, 0, 0);

      // random legal XLEN=32 traffic
      for (int it = 0; it < 10; it++) begin
         w = 1'($urandom_range(0, 1));
         f = w ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
         n = 1 << f[1:0];
         a = $urandom;
         a = a & ~32'(n - 1);
         access(0, w, f, a, {$urandom, $urandom}, {$urandom, $urandom}, 0,
                $urandom_range(0, 2), $urandom_range(0, 1), 0);
      end

      // XLEN=64 vectors
      access(1, 0, 3'b110, 32'h0000_0004, 64'h0, 64'hF000_0000_0000_0000, 0, 0, 0, 0);
      access(1, 0, 3'b010, 32'h0000_0004, 64'h0, 64'h8000_0000_0000_0000, 0, 0, 0, 0);
      access(1, 0, 3'b011, 32'h0000_0008, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 1, 0, 0);
      access(1, 1, 3'b000, 32'h0000_0005, 64'hCD, 64'h0, 0, 0, 0, 0);
      access(1, 1, 3'b011, 32'h0000_0010, 64'h0102_0304_0506_0708, 64'h0, 0, 0, 1, 0);
      access(1, 0, 3'b011, 32'h0000_0004, 64'h0, 64'h0, 0, 0, 0, 0);
      access(1, 0, 3'b100, 32'h0000_0007, 64'h0, 64'h8000_0000_0000_0000, 0, 0, 0, 0);

      // reset during WAIT on a store aborts it; a late bus response is ignored
      sel = 0;
      @(negedge clk);
      in_wen = 1; in_func3 = 3'b010; in_addr = 32'h0000_0020; in_wdata = 64'h55;
      v32 = 1'b1;
      @(posedge clk); #1;
      v32 = 1'b0;
      @(negedge clk);
      chk("abort_req", mreq_o, 1);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("abort");
      mem_rvalid = 1'b1; mem_rdata = 64'h1234;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("late_rvalid_valid", ov_o, 0);
      chk("late_rvalid_ready", rdy_o, 1);

      chk("rsp_q_empty", rsp_q.size(), 0);
      chk("cmd_q_empty", cmd_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
